// File: rtl/seg7_pkg.sv
// Shared widths, glyph patterns ({a..g}, active-high) and FSM states for the
// seven-segment scan decoder. Hex glyphs A..F become legal under SEG7_HEX_EN.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG7_GLYPH_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG7_GLYPH_F = 7'b1000111;

  localparam logic [BCD_W-1:0] SEG7_ERR_CODE = 4'hF;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } seg7_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the BCD-to-segment decoder: pattern in, {err, nibble} out.
// Hex glyphs A..F decode to 4'hA..4'hF only when SEG7_HEX_EN is defined.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             err,
  output logic [BCD_W-1:0] nibble
);

  always_comb begin
    err    = 1'b0;
    nibble = SEG7_ERR_CODE;
    case (seg)
      SEG7_GLYPH_0: nibble = 4'h0;
      SEG7_GLYPH_1: nibble = 4'h1;
      SEG7_GLYPH_2: nibble = 4'h2;
      SEG7_GLYPH_3: nibble = 4'h3;
      SEG7_GLYPH_4: nibble = 4'h4;
      SEG7_GLYPH_5: nibble = 4'h5;
      SEG7_GLYPH_6: nibble = 4'h6;
      SEG7_GLYPH_7: nibble = 4'h7;
      SEG7_GLYPH_8: nibble = 4'h8;
      SEG7_GLYPH_9: nibble = 4'h9;
`ifdef SEG7_HEX_EN
      SEG7_GLYPH_A: nibble = 4'hA;
      SEG7_GLYPH_B: nibble = 4'hB;
      SEG7_GLYPH_C: nibble = 4'hC;
      SEG7_GLYPH_D: nibble = 4'hD;
      SEG7_GLYPH_E: nibble = 4'hE;
      SEG7_GLYPH_F: nibble = 4'hF;
`endif
      default: begin
        err    = 1'b1;
        nibble = SEG7_ERR_CODE;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scanned seven-segment bus monitor: debounces each digit, decodes it into a
// staging frame and publishes the frame atomically once every digit is captured.
// Optional hex glyph support via SEG7_HEX_EN (handled in seg7_glyph_decode).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [DIGITS-1:0]       dig_sel,
  output logic [BCD_W*DIGITS-1:0] digits_out,
  output logic [DIGITS-1:0]       digit_err,
  output logic                    frame_err,
  output logic                    frame_valid
);

  localparam int          SAMPLE_W = DIGITS + SEG_W;
  localparam logic [3:0]  STABLE_N = 4'(STABLE_CYCLES);

  logic [SAMPLE_W-1:0]     sample, prev_q, prev_d;
  logic [3:0]              cnt_q, cnt_d;
  seg7_state_e             state_q, state_d;
  logic [DIGITS-1:0]       mask_q, mask_d;
  logic [BCD_W*DIGITS-1:0] stage_nib_q, stage_nib_d;
  logic [DIGITS-1:0]       stage_err_q, stage_err_d;
  logic [BCD_W*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]       derr_q, derr_d;
  logic                    ferr_q, ferr_d;
  logic                    fvalid_q, fvalid_d;

  logic                    sel_onehot;
  logic                    same;
  logic                    capture;
  logic                    publish;
  logic                    dec_err;
  logic [BCD_W-1:0]        dec_nib;

  seg7_glyph_decode u_decode (
    .seg    (seg_in),
    .err    (dec_err),
    .nibble (dec_nib)
  );

  assign sample     = {dig_sel, seg_in};
  assign same       = (sample == prev_q);
  assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
  // Capture happens on the edge where the counter reaches the threshold.
  assign capture    = (state_q == SETTLE) && sel_onehot && (cnt_d == STABLE_N);
  assign publish    = &mask_q;

  always_comb begin
    prev_d      = sample;
    cnt_d       = 4'd0;
    state_d     = state_q;
    mask_d      = publish ? '0 : mask_q;
    stage_nib_d = stage_nib_q;
    stage_err_d = stage_err_q;
    digits_d    = digits_q;
    derr_d      = derr_q;
    ferr_d      = ferr_q;
    fvalid_d    = publish;

    if (sel_onehot) begin
      if (!same)                  cnt_d = 4'd1;
      else if (cnt_q == STABLE_N) cnt_d = cnt_q;
      else                        cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      SETTLE:  if (capture) state_d = HOLD;
      HOLD:    if (!sel_onehot || !same) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase

    // A capture on the publish edge belongs to the next frame's mask.
    if (capture) begin
      mask_d = mask_d | dig_sel;
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_sel[i]) begin
          stage_nib_d[BCD_W*i +: BCD_W] = dec_nib;
          stage_err_d[i]                = dec_err;
        end
      end
    end

    if (publish) begin
      digits_d = stage_nib_q;
      derr_d   = stage_err_q;
      ferr_d   = |stage_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      state_q     <= SETTLE;
      mask_q      <= '0;
      stage_nib_q <= '0;
      stage_err_q <= '0;
      digits_q    <= '0;
      derr_q      <= '0;
      ferr_q      <= 1'b0;
      fvalid_q    <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      mask_q      <= mask_d;
      stage_nib_q <= stage_nib_d;
      stage_err_q <= stage_err_d;
      digits_q    <= digits_d;
      derr_q      <= derr_d;
      ferr_q      <= ferr_d;
      fvalid_q    <= fvalid_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_err   = derr_q;
  assign frame_err   = ferr_q;
  assign frame_valid = fvalid_q;

endmodule
